puf_sweep_controller: RTL and testbench

Sequencer that sits directly upstream of the delay PUF and drives its challenge/run inputs. It also consumes the PUF's synchronized result bit. It either sweeps all 2^PUF_LENGTH challenges and assembles a signature vector, or evaluates one host-supplied challenge. This replaces hand-timed stimulus with a synthesizable, cycle-exact controller for on-chip characterization.

---
 rtl/puf_sweep_controller.sv | 167 ++++++++++++++++
 tb/tb_puf_sweep_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_sweep_controller.sv
`default_nettype none
// ============================================================================
//  Module   : puf_sweep_controller
//  Purpose  : Drives challenge/run into a delay PUF. It can sweep every
//             challenge and assemble a signature vector, or it can evaluate
//             one host-supplied challenge and report its response bit.
//  Revision : 1.0  initial release
// ============================================================================
module puf_sweep_controller #(
  parameter int  PUF_LENGTH    = 8,
  parameter int  SETTLE_CYCLES = 10,
  parameter int  EVAL_CYCLES   = 10,
  localparam int SIG_W         = 1 << PUF_LENGTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_sweep,
  input  logic                  start_single,
  input  logic [PUF_LENGTH-1:0] challenge_in,
  input  logic                  puf_result,
  output logic [PUF_LENGTH-1:0] challenge,
  output logic                  run,
  output logic                  busy,
  output logic                  done,
  output logic                  resp_bit,
  output logic [SIG_W-1:0]      signature,
  output logic                  sig_valid
);

  // The wait counter is shared by SETTLE and EVAL, so size it for the longer one.
  localparam int C_CNT_MAX = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_EVAL   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t                  state_q,     state_d;
  logic [C_CNT_W-1:0]      cnt_q,       cnt_d;
  logic                    mode_q,      mode_d;     // 1 = sweep, 0 = single
  logic [PUF_LENGTH-1:0]   challenge_q, challenge_d;
  logic [SIG_W-1:0]        signature_q, signature_d;
  logic                    sig_valid_q, sig_valid_d;
  logic                    resp_bit_q,  resp_bit_d;
  logic                    run_q,       run_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;

  // Next-state and datapath logic; outputs derive from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    challenge_d = challenge_q;
    signature_d = signature_q;
    sig_valid_d = sig_valid_q;
    resp_bit_d  = resp_bit_q;

    case (state_q)
      ST_IDLE: begin
        // Sweep has priority when both requests arrive together.
        if (start_sweep) begin
          challenge_d = '0;
          signature_d = '0;
          sig_valid_d = 1'b0;
          mode_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_SETTLE;
        end else if (start_single) begin
          challenge_d = challenge_in;
          mode_d      = 1'b0;
          cnt_d       = '0;
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == C_CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_EVAL: begin
        if (cnt_q == C_CNT_W'(EVAL_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (mode_q) begin
          // Shift in from the top so that after the last challenge bit i holds response i.
          signature_d = {puf_result, signature_q[SIG_W-1:1]};
          // Last challenge found by compare; the register never wraps.
          if (challenge_q == {PUF_LENGTH{1'b1}}) begin
            sig_valid_d = 1'b1;
            state_d     = ST_FINISH;
          end else begin
            challenge_d = challenge_q + 1'b1;
            state_d     = ST_SETTLE;
          end
        end else begin
          resp_bit_d = puf_result;
          state_d    = ST_FINISH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    run_d  = (state_d == ST_EVAL) || (state_d == ST_SAMPLE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      challenge_q <= '0;
      signature_q <= '0;
      sig_valid_q <= 1'b0;
      resp_bit_q  <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      challenge_q <= challenge_d;
      signature_q <= signature_d;
      sig_valid_q <= sig_valid_d;
      resp_bit_q  <= resp_bit_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign challenge = challenge_q;
  assign run       = run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign resp_bit  = resp_bit_q;
  assign signature = signature_q;
  assign sig_valid = sig_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_sweep_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_puf_sweep_controller
//  Purpose  : Self-checking bench for puf_sweep_controller with a parity PUF
//             stub (2-cycle latency, valid only while run is high).
//  Revision : 1.0  initial release
// ============================================================================
module tb_puf_sweep_controller;

  localparam int PL    = 4;
  localparam int SC    = 2;
  localparam int EC    = 3;
  localparam int SW    = 1 << PL;
  localparam int L_ONE = SC + EC + 1;           // cycles per challenge
  localparam int LAT_SINGLE = L_ONE + 1;        // start edge to done cycle
  localparam int LAT_SWEEP  = SW * L_ONE + 1;
  localparam int BOUND      = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_sweep, start_single;
  logic [PL-1:0] challenge_in;
  logic          puf_result;
  logic [PL-1:0] challenge;
  logic          run, busy, done, resp_bit, sig_valid;
  logic [SW-1:0] signature;

  puf_sweep_controller #(
    .PUF_LENGTH   (PL),
    .SETTLE_CYCLES(SC),
    .EVAL_CYCLES  (EC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_sweep (start_sweep),
    .start_single(start_single),
    .challenge_in(challenge_in),
    .puf_result  (puf_result),
    .challenge   (challenge),
    .run         (run),
    .busy        (busy),
    .done        (done),
    .resp_bit    (resp_bit),
    .signature   (signature),
    .sig_valid   (sig_valid)
  );

  always #5 clk = ~clk;

  // PUF stub: parity of the challenge, two flops of latency, zero while not running.
  logic p1, p2;
  always @(posedge clk) begin
    p1 <= run ? ^challenge : 1'b0;
    p2 <= p1;
  end
  assign puf_result = p2;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard entries pushed when a start is driven, popped on done.
  typedef struct {
    logic          sweep;
    logic [SW-1:0] sig;
    logic          sv;
    logic          resp;
    logic [PL-1:0] chal;
    int            lat;
  } exp_t;
  exp_t sb[$];

  logic [SW-1:0] m_sig  = '0;
  logic          m_sv   = 1'b0;
  logic          m_resp = 1'b0;
  int            exp_dones = 0;

  function automatic logic [SW-1:0] sweep_model();
    logic [SW-1:0] s;
    for (int i = 0; i < SW; i++) begin
      logic [PL-1:0] c;
      c    = PL'(i);
      s[i] = ^c;
    end
    return s;
  endfunction

  // Run-timing monitor: run low exactly SC busy cycles before each rise, high EC+1, challenge frozen while high.
  int   low_cnt = 0, high_cnt = 0, done_cnt = 0;
  logic prev_run = 1'b0;
  logic [PL-1:0] prev_chal = '0;
  always @(negedge clk) begin
    if (reset) begin
      low_cnt  = 0;
      high_cnt = 0;
    end else begin
      if (done) done_cnt++;
      if (run && !prev_run) check("run_low_len", low_cnt, SC);
      if (!run && prev_run) check("run_high_len", high_cnt, EC + 1);
      if (run && prev_run) check("chal_stable", challenge, prev_chal);
      if (run) begin
        high_cnt++;
        low_cnt = 0;
      end else begin
        high_cnt = 0;
        if (busy) low_cnt++;
        else      low_cnt = 0;
      end
    end
    prev_run  = run;
    prev_chal = challenge;
  end

  // Pulse a start request and record the expected outcome.
  task automatic start_op(input logic sw, input logic si, input logic [PL-1:0] cin);
    exp_t e;
    @(negedge clk);
    start_sweep  = sw;
    start_single = si;
    challenge_in = cin;
    if (sw) begin
      m_sig  = sweep_model();
      m_sv   = 1'b1;
      e.sweep = 1'b1; e.sig = m_sig; e.sv = 1'b1; e.resp = m_resp;
      e.chal  = '1;   e.lat = LAT_SWEEP;
    end else begin
      m_resp = ^cin;
      e.sweep = 1'b0; e.sig = m_sig; e.sv = m_sv; e.resp = m_resp;
      e.chal  = cin;  e.lat = LAT_SINGLE;
    end
    sb.push_back(e);
    exp_dones++;
    @(negedge clk);
    start_sweep  = 1'b0;
    start_single = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head.
  task automatic wait_done(input int mid_single_at);
    int   cyc;
    exp_t e;
    cyc = 1;
    while (!done && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (cyc == mid_single_at) begin
        start_single = 1'b1;
        challenge_in = 4'h7;
        @(negedge clk);
        cyc++;
        start_single = 1'b0;
      end
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("latency",   cyc,       e.lat);
    check("signature", signature, e.sig);
    check("sig_valid", sig_valid, e.sv);
    check("resp_bit",  resp_bit,  e.resp);
    check("run_at_done", run,     1'b0);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle",  done, 1'b0);
    check("chal_hold",       challenge, e.chal);
  endtask

  initial begin
    reset = 1'b1; start_sweep = 1'b0; start_single = 1'b0; challenge_in = '0;
    repeat (3) @(negedge clk);
    check("rst_run", run, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sig", signature, 16'h0);
    check("rst_sv", sig_valid, 1'b0);
    check("rst_resp", resp_bit, 1'b0);
    check("rst_chal", challenge, 4'h0);
    reset = 1'b0;
    @(negedge clk);

    // Full sweep.
    start_op(1'b1, 1'b0, 4'h0);
    wait_done(0);

    // Single evaluation after a sweep keeps the signature.
    start_op(1'b0, 1'b1, 4'hB);
    wait_done(0);
    start_op(1'b0, 1'b1, 4'h3);
    wait_done(0);

    // Both requests together: sweep wins.
    start_op(1'b1, 1'b1, 4'hE);
    wait_done(0);

    // Single request in the middle of a sweep is dropped.
    start_op(1'b1, 1'b0, 4'h0);
    wait_done(20);
    repeat (3) @(negedge clk);
    check("no_queued_start", busy, 1'b0);

    // Reset in the middle of a sweep.
    start_op(1'b1, 1'b0, 4'h0);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_run", run, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_chal", challenge, 4'h0);
    check("midrst_sig", signature, 16'h0);
    check("midrst_sv", sig_valid, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_resp", resp_bit, 1'b0);
    void'(sb.pop_front());
    exp_dones--;
    m_sig = '0; m_sv = 1'b0; m_resp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Recovery sweep, then a single with challenge 0.
    start_op(1'b1, 1'b0, 4'h0);
    wait_done(0);
    start_op(1'b0, 1'b1, 4'h0);
    wait_done(0);

    check("done_pulses", done_cnt, exp_dones);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
